// File: rtl/wm_pkg.sv
// Watermark embedding engine: shared types and helpers.
// Embedding modes, FSM encoding and the saturation limit.
package wm_pkg;

    typedef enum logic [1:0] {
        BYPASS = 2'd0,
        LSB    = 2'd1,
        XOR    = 2'd2,
        BLEND  = 2'd3
    } wm_mode_t;

    typedef logic [1:0] wm_state_t;

    localparam wm_state_t ST_IDLE  = 2'd0;
    localparam wm_state_t ST_RUN   = 2'd1;
    localparam wm_state_t ST_DRAIN = 2'd2;
    localparam wm_state_t ST_DONE  = 2'd3;

    function automatic logic [63:0] sat_max(
        input int unsigned w
    );
        if (w >= 64)
            sat_max = '1;
        else
            sat_max = (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/wm_embed_engine_if.sv
// Memory-side bus of the watermark engine.
// Shared read port for host/watermark RAMs, write port to output RAM.
interface wm_embed_engine_if #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 12
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  pix_rdata;
    logic              wm_rdata;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;

    modport master (
        output rd_en, rd_addr,
        output wr_en, wr_addr, wr_data,
        input  pix_rdata, wm_rdata
    );

    modport slave (
        input  rd_en, rd_addr,
        input  wr_en, wr_addr, wr_data,
        output pix_rdata, wm_rdata
    );
endinterface

// File: rtl/wm_pixel_op.sv
// Combinational per-pixel watermark operation.
// Applies one of four embedding modes and flags a changed pixel.
module wm_pixel_op
    import wm_pkg::*;
#(
    parameter  int PIX_W = 8,
    localparam int PL_W  = $clog2(PIX_W)
) (
    input  logic [PIX_W-1:0] p,
    input  logic             w,
    input  wm_mode_t         mode,
    input  logic [PL_W-1:0]  plane,
    input  logic [PIX_W-1:0] alpha,
    output logic [PIX_W-1:0] out,
    output logic             changed
);

    localparam logic [PIX_W-1:0] SAT = PIX_W'(sat_max(PIX_W));

    logic [PIX_W-1:0] mask;
    logic [PIX_W-1:0] wm_mask;
    logic [PIX_W:0]   sum;

    always_comb begin
        mask    = PIX_W'(1) << plane;
        wm_mask = w ? mask : '0;
        sum     = {1'b0, p} + {1'b0, (w ? alpha : '0)};
        out     = p;
        unique case (1'b1)
            mode == BYPASS: out = p;
            mode == LSB:    out = (p & ~mask) | wm_mask;
            mode == XOR:    out = p ^ wm_mask;
            mode == BLEND:  out = sum[PIX_W] ? SAT : sum[PIX_W-1:0];
            default:        out = p;
        endcase
        changed = (out != p);
    end

endmodule

// File: rtl/wm_embed_engine.sv
// Streaming watermark embedding engine, one pixel per clock.
// Read at E(k), RAM data at E(k+1), registered write at E(k+2).
module wm_embed_engine
    import wm_pkg::*;
#(
    parameter  int PIX_W   = 8,
    parameter  int NUM_PIX = 4096,
    parameter  int ADDR_W  = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1,
    localparam int PL_W    = $clog2(PIX_W),
    localparam int CNT_W   = ADDR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [PL_W-1:0]  plane,
    input  logic [PIX_W-1:0] alpha,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] changed_cnt,
    wm_embed_engine_if.master m
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PIX - 1);

    wm_state_t         state;
    wm_state_t         state_nxt;
    wm_mode_t          cfg_mode;
    logic [PL_W-1:0]   cfg_plane;
    logic [PIX_W-1:0]  cfg_alpha;
    logic [ADDR_W-1:0] addr;
    logic              rd_en_q;
    logic              drain_last;
    logic              v1;
    logic [ADDR_W-1:0] a1;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [PIX_W-1:0]  wr_data_q;
    logic [PIX_W-1:0]  op_out;
    logic              op_changed;
    logic              active;
    logic              kill;
    logic              accept;
    logic              last_addr;

    assign active    = (state == ST_RUN) || (state == ST_DRAIN);
    assign kill      = active && abort;
    assign accept    = (state == ST_IDLE) && start;
    assign last_addr = (addr == LAST);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:
                if (start) state_nxt = ST_RUN;
            ST_RUN:
                if (abort)          state_nxt = ST_IDLE;
                else if (last_addr) state_nxt = ST_DRAIN;
            ST_DRAIN:
                if (abort)           state_nxt = ST_IDLE;
                else if (drain_last) state_nxt = ST_DONE;
            ST_DONE:
                state_nxt = ST_IDLE;
        endcase
    end

    wm_pixel_op #(.PIX_W(PIX_W)) u_op (
        .p       (m.pix_rdata),
        .w       (m.wm_rdata),
        .mode    (cfg_mode),
        .plane   (cfg_plane),
        .alpha   (cfg_alpha),
        .out     (op_out),
        .changed (op_changed)
    );

    // Status strobes are flops fed from state_nxt so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_en_q    <= 1'b0;
            drain_last <= 1'b0;
        end else begin
            state      <= state_nxt;
            busy       <= (state_nxt == ST_RUN) ||
                          (state_nxt == ST_DRAIN);
            done       <= (state_nxt == ST_DONE);
            rd_en_q    <= (state_nxt == ST_RUN);
            drain_last <= (state == ST_DRAIN) &&
                          (state_nxt == ST_DRAIN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_mode  <= BYPASS;
            cfg_plane <= '0;
            cfg_alpha <= '0;
            addr      <= '0;
        end else if (accept) begin
            cfg_mode  <= wm_mode_t'(mode);
            cfg_plane <= plane;
            cfg_alpha <= alpha;
            addr      <= '0;
        end else if (state == ST_RUN && !abort && !last_addr) begin
            addr      <= addr + ADDR_W'(1);
        end
    end

    // Abort drops the in-flight stages rather than letting them write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1          <= 1'b0;
            a1          <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            changed_cnt <= '0;
        end else begin
            v1      <= rd_en_q && !kill;
            a1      <= addr;
            wr_en_q <= v1 && !kill;
            if (v1 && !kill) begin
                wr_addr_q <= a1;
                wr_data_q <= op_out;
            end
            if (accept)
                changed_cnt <= '0;
            else if (v1 && !kill && op_changed)
                changed_cnt <= changed_cnt + CNT_W'(1);
        end
    end

    assign m.rd_en   = rd_en_q;
    assign m.rd_addr = addr;
    assign m.wr_en   = wr_en_q;
    assign m.wr_addr = wr_addr_q;
    assign m.wr_data = wr_data_q;

endmodule

// File: tb/tb_wm_embed_engine.sv
// Directed bench for wm_embed_engine with NUM_PIX=16, PIX_W=8.
// Vector table for the modes plus abort, restart and reset sequences.
module tb_wm_embed_engine;

    localparam int PW = 8;
    localparam int NP = 16;
    localparam int AW = 4;

    typedef struct {
        logic [1:0] mode;
        logic [2:0] plane;
        logic [7:0] alpha;
        bit         ramp;
        logic [7:0] pconst;
        int         wpat;
        bit         exp_ramp;
        logic [7:0] exp_e;
        logic [7:0] exp_o;
        int         exp_cnt;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    mode = '0;
    logic [2:0]    plane = '0;
    logic [7:0]    alpha = '0;
    logic          busy;
    logic          done;
    logic [AW:0]   changed_cnt;

    wm_embed_engine_if #(.PIX_W(PW), .ADDR_W(AW)) mif ();

    wm_embed_engine #(.PIX_W(PW), .NUM_PIX(NP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .mode        (mode),
        .plane       (plane),
        .alpha       (alpha),
        .busy        (busy),
        .done        (done),
        .changed_cnt (changed_cnt),
        .m           (mif)
    );

    always #5 clk = ~clk;

    logic [7:0] pix_mem [NP];
    logic       wm_mem  [NP];
    logic [7:0] got     [NP];
    int         wr_n = 0;
    int         done_n = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always @(posedge clk) begin
        if (mif.rd_en) begin
            mif.pix_rdata <= pix_mem[mif.rd_addr];
            mif.wm_rdata  <= wm_mem[mif.rd_addr];
        end
    end

    always @(negedge clk) begin
        if (mif.wr_en) begin
            got[mif.wr_addr] = mif.wr_data;
            wr_n++;
        end
        if (done) done_n++;
    end

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        for (int k = 0; k < NP; k++) begin
            pix_mem[k] = v.ramp ? 8'(k) : v.pconst;
            case (v.wpat)
                0:       wm_mem[k] = 1'b0;
                1:       wm_mem[k] = 1'b1;
                default: wm_mem[k] = (k % 2 == 0);
            endcase
            got[k] = 8'hxx;
        end
    endtask

    // Called at a negedge; returns at a negedge one cycle after done.
    task automatic run_job(input vec_t v, input int id,
                           input bit with_abort);
        int edges;
        int d0;
        logic [7:0] e;
        load(v);
        mode  = v.mode;
        plane = v.plane;
        alpha = v.alpha;
        abort = with_abort;
        start = 1'b1;
        wr_n  = 0;
        d0    = done_n;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        mode  = ~v.mode;
        plane = ~v.plane;
        alpha = ~v.alpha;
        check($sformatf("v%0d busy", id), 32'(busy), 1);
        edges = 0;
        while (edges < 100) begin
            @(negedge clk);
            if (done) break;
            @(posedge clk);
            edges++;
        end
        check($sformatf("v%0d latency", id), edges, NP + 2);
        check($sformatf("v%0d busy@done", id), 32'(busy), 0);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("v%0d cnt", id),
              32'(changed_cnt), v.exp_cnt);
        check($sformatf("v%0d writes", id), wr_n, NP);
        check($sformatf("v%0d dones", id), done_n - d0, 1);
        for (int k = 0; k < NP; k++) begin
            if (v.exp_ramp) e = 8'(k);
            else e = (k % 2 == 0) ? v.exp_e : v.exp_o;
            check($sformatf("v%0d px%0d", id, k),
                  32'(got[k]), 32'(e));
        end
    endtask

    vec_t vecs [9];

    initial begin
        int d0;
        int seen;
        vecs[0] = '{2'd0, 3'd0, 8'h00, 1, 8'h00, 1,
                    1, 8'h00, 8'h00, 0};
        vecs[1] = '{2'd1, 3'd0, 8'h00, 0, 8'hAA, 2,
                    0, 8'hAB, 8'hAA, 8};
        vecs[2] = '{2'd2, 3'd7, 8'h00, 0, 8'h80, 1,
                    0, 8'h00, 8'h00, 16};
        vecs[3] = '{2'd3, 3'd0, 8'h40, 0, 8'hF0, 1,
                    0, 8'hFF, 8'hFF, 16};
        vecs[4] = '{2'd3, 3'd0, 8'h40, 0, 8'h10, 1,
                    0, 8'h50, 8'h50, 16};
        vecs[5] = '{2'd3, 3'd0, 8'h40, 0, 8'h10, 0,
                    0, 8'h10, 8'h10, 0};
        vecs[6] = '{2'd1, 3'd3, 8'h00, 0, 8'h00, 2,
                    0, 8'h08, 8'h00, 8};
        vecs[7] = '{2'd2, 3'd0, 8'h00, 0, 8'h55, 2,
                    0, 8'h54, 8'h55, 8};
        vecs[8] = '{2'd3, 3'd0, 8'h0F, 0, 8'hF0, 1,
                    0, 8'hFF, 8'hFF, 16};

        #1;
        check("reset outs",
              {busy, done, mif.rd_en, mif.rd_addr, mif.wr_en,
               mif.wr_addr, mif.wr_data, changed_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            run_job(vecs[i], i, i == 8);

        // Abort five cycles into RUN
        load(vecs[2]);
        mode = 2'd2; plane = 3'd7;
        d0 = done_n;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort wr_en", 32'(mif.wr_en), 0);
        check("abort rd_en", 32'(mif.rd_en), 0);
        check("abort busy", 32'(busy), 0);
        check("abort cnt", 32'(changed_cnt), 3);
        repeat (25) @(negedge clk);
        check("abort no done", done_n - d0, 0);
        run_job(vecs[1], 10, 0);

        // Start pulses during RUN and during DONE
        load(vecs[0]);
        mode = 2'd0;
        d0 = done_n;
        wr_n = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 0;
        for (int t = 0; t < 100 && seen == 0; t++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("restart done seen", seen, 1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (25) @(negedge clk);
        check("restart dones", done_n - d0, 1);
        check("restart writes", wr_n, NP);
        check("restart idle", 32'(busy), 0);

        // Asynchronous reset mid-RUN
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun reset outs",
              {busy, done, mif.rd_en, mif.rd_addr, mif.wr_en,
               mif.wr_addr, mif.wr_data, changed_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_n;
        repeat (25) @(negedge clk);
        check("post reset idle", 32'(busy), 0);
        check("post reset no done", done_n - d0, 0);
        run_job(vecs[7], 11, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
